// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC channel sequencer:
// sequencer states, result-word layout and error-count limit.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PUSH
    } seq_state_t;

    localparam int CHAN_LSB = 16;
    localparam int CHAN_W   = 5;
    localparam int OVF_BIT  = 24;
    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ERR_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head.
// A push into a full FIFO succeeds when a pop happens on the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin MAX10 ADC sequencer: one command in flight, per-channel
// averaging, results streamed to the CPU through a small FIFO.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CHANNEL_BASE   = 1,
    parameter int NUM_CHANNELS   = 4,
    parameter int DATA_WIDTH     = 12,
    parameter int AVG_LOG2       = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_in,
    output logic                  command_valid_out,
    output logic [4:0]            command_channel_out,
    output logic                  command_startofpacket_out,
    output logic                  command_endofpacket_out,
    input  logic                  command_ready_in,
    input  logic                  response_valid_in,
    input  logic [4:0]            response_channel_in,
    input  logic [DATA_WIDTH-1:0] response_data_in,
    output logic [31:0]           adc_out,
    output logic                  adc_stb_out,
    input  logic                  adc_ack_in,
    output logic [15:0]           error_count_out
);

    localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [4:0]       IDX_LAST = 5'(NUM_CHANNELS - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [4:0]       idx;
    logic [4:0]       chan;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  tmo;
    logic [15:0]      err_cnt;
    logic             drop_flag;

    logic             cmd_fire;
    logic             rsp_hit;
    logic             rsp_miss;
    logic             tmo_hit;
    logic             in_push;
    logic             push_ok;
    logic [31:0]      result_word;

    logic             fifo_pop;
    logic [31:0]      fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;

    assign chan     = 5'(CHANNEL_BASE) + idx;
    assign in_push  = (state == ST_PUSH);
    assign cmd_fire = (state == ST_ISSUE) && command_ready_in;
    assign rsp_hit  = (state == ST_WAIT) && response_valid_in
                   && (response_channel_in == chan);
    assign rsp_miss = (state == ST_WAIT) && response_valid_in
                   && (response_channel_in != chan);
    assign tmo_hit  = (state == ST_WAIT) && !response_valid_in
                   && (tmo == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (enable_in) state_nxt = ST_ISSUE;
            ST_ISSUE: if (command_ready_in) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (rsp_hit)
                    state_nxt = (cnt == LAST_CNT) ? ST_PUSH : ST_ISSUE;
                else if (rsp_miss || tmo_hit)
                    state_nxt = ST_ISSUE;
            end
            ST_PUSH:  state_nxt = enable_in ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        command_valid_out         = 1'b0;
        command_channel_out       = 5'd0;
        command_startofpacket_out = 1'b0;
        command_endofpacket_out   = 1'b0;
        if (state == ST_ISSUE) begin
            command_valid_out         = 1'b1;
            command_channel_out       = chan;
            command_startofpacket_out = 1'b1;
            command_endofpacket_out   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            acc       <= '0;
            cnt       <= '0;
            tmo       <= '0;
            err_cnt   <= '0;
            drop_flag <= 1'b0;
        end else begin
            if (cmd_fire)
                tmo <= '0;
            else if (state == ST_WAIT)
                tmo <= tmo + 1'b1;
            if (rsp_hit) begin
                acc <= acc + ACC_W'(response_data_in);
                cnt <= cnt + 1'b1;
            end
            if (rsp_miss || tmo_hit)
                err_cnt <= sat_inc(err_cnt);
            if (in_push) begin
                acc       <= '0;
                cnt       <= '0;
                idx       <= (idx == IDX_LAST) ? 5'd0 : idx + 5'd1;
                drop_flag <= !push_ok;
            end
        end
    end

    // Truncating mean: the top DATA_WIDTH bits of the running sum.
    always_comb begin
        result_word                          = '0;
        result_word[DATA_WIDTH-1:0]          = acc[ACC_W-1:AVG_LOG2];
        result_word[CHAN_LSB +: CHAN_W]      = chan;
        result_word[OVF_BIT]                 = drop_flag;
    end

    assign fifo_pop = adc_ack_in && !fifo_empty;
    assign push_ok  = !fifo_full || fifo_pop;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_push),
        .wdata (result_word),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign adc_stb_out     = !fifo_empty;
    assign adc_out         = adc_stb_out ? fifo_rdata : 32'd0;
    assign error_count_out = err_cnt;

endmodule
